hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core; sits beside the decode-stage control unit and drives per-stage stall and flush enables. Resolves load-use hazards, taken branches/JALR, data-memory wait states, and the SCALL/SBREAK drain-and-halt sequence. Uses a registered state machine with combinational stall/flush outputs, so a hazard raised in cycle N is acted on in cycle N.

---
 rtl/hazard_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : stall/flush sequencing for the five-stage core (load-use,
//               taken branch, data-memory wait, SCALL/SBREAK drain-and-halt).
// Optional build macro: HAZARD_PERF_CNT_EN (stall-cycle / flush-event counters)
// Revision: 1.0
// ============================================================================

package hazard_ctrl_pkg;
  typedef enum logic [0:0] {
    SYSOP_SCALL  = 1'b0,
    SYSOP_SBREAK = 1'b1
  } t_sysop;
endpackage

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_uses_rs1,
  input  logic        i_id_uses_rs2,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_regwrite,
  input  logic [1:0]  i_ex_memtoreg,
  input  logic        i_ex_br_taken,
  input  logic        i_ex_sys_valid,
  input  t_sysop      i_ex_sysop,
  input  logic        i_mem_req,
  input  logic        i_mem_ack,
  input  logic        i_resume,
  output logic        o_stall_if,
  output logic        o_stall_id,
  output logic        o_stall_ex,
  output logic        o_stall_mem,
  output logic        o_flush_id,
  output logic        o_flush_ex,
  output logic        o_halted,
  output t_sysop      o_halt_cause
`ifdef HAZARD_PERF_CNT_EN
 ,output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_events
`endif
);

  localparam logic [3:0] C_DRAIN_LOAD = 4'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALT     = 2'd3
  } t_state;

  t_state     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  t_sysop     halt_cause_q, halt_cause_d;
  logic       halted_q, halted_d;

  logic w_mw, w_lu;
  logic w_stall_if, w_stall_id, w_stall_ex, w_stall_mem;
  logic w_flush_id, w_flush_ex;

  assign w_mw = i_mem_req & ~i_mem_ack;
  assign w_lu = i_ex_regwrite & (i_ex_memtoreg == 2'b01) & (i_ex_rd != 5'd0) &
                ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) |
                 (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    halt_cause_d = halt_cause_q;
    w_stall_if   = 1'b0;
    w_stall_id   = 1'b0;
    w_stall_ex   = 1'b0;
    w_stall_mem  = 1'b0;
    w_flush_id   = 1'b0;
    w_flush_ex   = 1'b0;
    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        state_d = ST_RUN;
        if (w_mw) begin
          // a branch/sys op in EX simply waits here and is seen again after the wait
          w_stall_if  = 1'b1;
          w_stall_id  = 1'b1;
          w_stall_ex  = 1'b1;
          w_stall_mem = 1'b1;
          state_d     = ST_MEM_WAIT;
        end else if (i_ex_sys_valid) begin
          w_stall_if   = 1'b1;
          w_flush_id   = 1'b1;
          halt_cause_d = i_ex_sysop;
          cnt_d        = C_DRAIN_LOAD;
          state_d      = ST_DRAIN;
        end else if (i_ex_br_taken) begin
          w_flush_id = 1'b1;
          w_flush_ex = 1'b1;
        end else if (w_lu) begin
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_flush_ex = 1'b1;
        end
      end
      ST_DRAIN: begin
        w_stall_if = 1'b1;
        w_stall_id = 1'b1;
        w_stall_ex = 1'b1;
        if (w_mw) begin
          w_stall_mem = 1'b1;
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_HALT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HALT: begin
        w_stall_if  = 1'b1;
        w_stall_id  = 1'b1;
        w_stall_ex  = 1'b1;
        w_stall_mem = 1'b1;
        if (i_resume) begin
          // retire the parked sys op so it cannot trap again
          w_flush_ex = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_RUN;
      cnt_q        <= 4'd0;
      halt_cause_q <= SYSOP_SCALL;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      halt_cause_q <= halt_cause_d;
      halted_q     <= halted_d;
    end
  end

  // reset is asynchronous, so the combinational enables are masked by it too
  assign o_stall_if   = w_stall_if  & ~i_rst;
  assign o_stall_id   = w_stall_id  & ~i_rst;
  assign o_stall_ex   = w_stall_ex  & ~i_rst;
  assign o_stall_mem  = w_stall_mem & ~i_rst;
  assign o_flush_id   = w_flush_id  & ~i_rst;
  assign o_flush_ex   = w_flush_ex  & ~i_rst;
  assign o_halted     = halted_q;
  assign o_halt_cause = halt_cause_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (o_stall_if && (state_q != ST_HALT)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (o_flush_ex) begin
      flush_events_d = flush_events_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign o_stall_cycles = stall_cycles_q;
  assign o_flush_events = flush_events_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl : directed self-checking bench for hazard_ctrl.
// Revision: 1.0
// ============================================================================
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int DRAIN = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, rw;
  logic [1:0] mtr;
  logic       br, sys;
  t_sysop     sysop;
  logic       req, ack, resume;

  logic   o_stall_if, o_stall_id, o_stall_ex, o_stall_mem;
  logic   o_flush_id, o_flush_ex, o_halted;
  t_sysop o_halt_cause;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] o_stall_cycles, o_flush_events;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_id_rs1      (rs1),
    .i_id_rs2      (rs2),
    .i_id_uses_rs1 (u1),
    .i_id_uses_rs2 (u2),
    .i_ex_rd       (rd),
    .i_ex_regwrite (rw),
    .i_ex_memtoreg (mtr),
    .i_ex_br_taken (br),
    .i_ex_sys_valid(sys),
    .i_ex_sysop    (sysop),
    .i_mem_req     (req),
    .i_mem_ack     (ack),
    .i_resume      (resume),
    .o_stall_if    (o_stall_if),
    .o_stall_id    (o_stall_id),
    .o_stall_ex    (o_stall_ex),
    .o_stall_mem   (o_stall_mem),
    .o_flush_id    (o_flush_id),
    .o_flush_ex    (o_flush_ex),
    .o_halted      (o_halted),
    .o_halt_cause  (o_halt_cause)
`ifdef HAZARD_PERF_CNT_EN
   ,.o_stall_cycles(o_stall_cycles),
    .o_flush_events(o_flush_events)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: the controller is either running, draining with a
  // number of free (non-waiting) cycles left, or halted.
  int     m_mode;   // 0 running, 1 draining, 2 halted
  int     m_left;
  t_sysop m_cause;
  int     m_flushes;

  task automatic model_cycle();
    logic       mw, lu;
    logic [5:0] e;  // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex}
    mw = req & ~ack;
    lu = rw && (mtr == 2'b01) && (rd != 5'd0) &&
         ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    e  = 6'b0;
    if (rst) begin
      check("model_halted", {31'd0, o_halted}, 32'd0);
      check("model_cause", {31'd0, o_halt_cause}, {31'd0, SYSOP_SCALL});
      m_mode    = 0;
      m_left    = 0;
      m_cause   = SYSOP_SCALL;
      m_flushes = 0;
    end else begin
      check("model_halted", {31'd0, o_halted}, {31'd0, (m_mode == 2)});
      check("model_cause", {31'd0, o_halt_cause}, {31'd0, m_cause});
      if (m_mode == 2) begin
        e = {4'b1111, 1'b0, resume};
        if (resume) m_mode = 0;
      end else if (m_mode == 1) begin
        e = {3'b111, mw, 2'b00};
        if (!mw) begin
          m_left = m_left - 1;
          if (m_left <= 0) m_mode = 2;
        end
      end else if (mw) begin
        e = 6'b111100;
      end else if (sys) begin
        e       = 6'b100010;
        m_mode  = 1;
        m_left  = DRAIN;
        m_cause = sysop;
      end else if (br) begin
        e = 6'b000011;
      end else if (lu) begin
        e = 6'b110001;
      end
      if (e[0]) m_flushes++;
    end
    check("model_outputs",
          {26'd0, o_stall_if, o_stall_id, o_stall_ex, o_stall_mem, o_flush_id, o_flush_ex},
          {26'd0, e});
  endtask

  initial begin
    m_mode    = 0;
    m_left    = 0;
    m_cause   = SYSOP_SCALL;
    m_flushes = 0;
    forever begin
      @(negedge clk);
      model_cycle();
    end
  end

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    u1 = 1'b0; u2 = 1'b0; rw = 1'b0; mtr = 2'b00;
    br = 1'b0; sys = 1'b0; sysop = SYSOP_SCALL;
    req = 1'b0; ack = 1'b0; resume = 1'b0;
  endtask

  task automatic load_use_x5();
    rd = 5'd5; rw = 1'b1; mtr = 2'b01; u2 = 1'b1; rs2 = 5'd5;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    req = 1'b1;
    load_use_x5();
    settle();
    check("rst_stall_mem", {31'd0, o_stall_mem}, 32'd0);
    check("rst_stall_id", {31'd0, o_stall_id}, 32'd0);
    check("rst_cause", {31'd0, o_halt_cause}, {31'd0, SYSOP_SCALL});
    next(); next();
    rst = 1'b0;
    idle();
    next();

    // load-use on x5
    load_use_x5();
    settle();
    check("lu_stall_if", {31'd0, o_stall_if}, 32'd1);
    check("lu_stall_id", {31'd0, o_stall_id}, 32'd1);
    check("lu_flush_ex", {31'd0, o_flush_ex}, 32'd1);
    check("lu_flush_id", {31'd0, o_flush_id}, 32'd0);
    next(); idle();
    settle();
    check("lu_after_stall_if", {31'd0, o_stall_if}, 32'd0);
    next();

    // load to x0 never hazards
    rd = 5'd0; rw = 1'b1; mtr = 2'b01; u1 = 1'b1; u2 = 1'b1;
    settle();
    check("lu_x0_stall_id", {31'd0, o_stall_id}, 32'd0);
    next();
    // non-load writeback source: no hazard
    load_use_x5(); mtr = 2'b00;
    next();
    // hazard through rs1
    idle(); rd = 5'd7; rw = 1'b1; mtr = 2'b01; u1 = 1'b1; rs1 = 5'd7;
    next(); idle();

    // taken branch beats load-use
    load_use_x5(); br = 1'b1;
    settle();
    check("br_flush_id", {31'd0, o_flush_id}, 32'd1);
    check("br_flush_ex", {31'd0, o_flush_ex}, 32'd1);
    check("br_stall_id", {31'd0, o_stall_id}, 32'd0);
    next(); idle();
    next();

    // three wait cycles with a load-use pending, then ack
    load_use_x5(); req = 1'b1; ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("mw_stall_mem", {31'd0, o_stall_mem}, 32'd1);
      next();
    end
    ack = 1'b1;
    settle();
    check("mw_ack_stall_mem", {31'd0, o_stall_mem}, 32'd0);
    check("mw_ack_lu_stall_id", {31'd0, o_stall_id}, 32'd1);
    next(); idle();
    settle();
    check("mw_done_stall_if", {31'd0, o_stall_if}, 32'd0);
    next();

    // branch held across a wait
    req = 1'b1; br = 1'b1;
    settle();
    check("mw_br_flush_id", {31'd0, o_flush_id}, 32'd0);
    next();
    ack = 1'b1;
    settle();
    check("mw_br_ack_flush_id", {31'd0, o_flush_id}, 32'd1);
    next(); idle();
    next();

    // SBREAK trap (branch also asserted: sys wins), one wait cycle in DRAIN
    sys = 1'b1; sysop = SYSOP_SBREAK; br = 1'b1;
    settle();
    check("trap_stall_if", {31'd0, o_stall_if}, 32'd1);
    check("trap_flush_id", {31'd0, o_flush_id}, 32'd1);
    check("trap_flush_ex", {31'd0, o_flush_ex}, 32'd0);
    next(); idle();
    settle();
    check("drain1_stall_ex", {31'd0, o_stall_ex}, 32'd1);
    check("drain1_flush_id", {31'd0, o_flush_id}, 32'd0);
    next();
    req = 1'b1;
    settle();
    check("drain_mw_stall_mem", {31'd0, o_stall_mem}, 32'd1);
    next(); idle();
    br = 1'b1;
    settle();
    check("drain_br_ignored", {31'd0, o_flush_id}, 32'd0);
    check("drain3_halted", {31'd0, o_halted}, 32'd0);
    next(); idle();
    sys = 1'b1;
    settle();
    check("halt_rise", {31'd0, o_halted}, 32'd1);
    check("halt_cause", {31'd0, o_halt_cause}, {31'd0, SYSOP_SBREAK});
    check("halt_no_flush", {31'd0, o_flush_ex}, 32'd0);
    next(); idle();
    resume = 1'b1;
    settle();
    check("resume_flush_ex", {31'd0, o_flush_ex}, 32'd1);
    check("resume_still_halted", {31'd0, o_halted}, 32'd1);
    next(); idle();
    settle();
    check("resumed_halted", {31'd0, o_halted}, 32'd0);
    check("resumed_stall_if", {31'd0, o_stall_if}, 32'd0);
    next();
    resume = 1'b1;
    settle();
    check("resume_in_run", {31'd0, o_flush_ex}, 32'd0);
    next(); idle();

    // SCALL trap aborted by reset during DRAIN
    sys = 1'b1; sysop = SYSOP_SCALL;
    next(); idle();
    settle();
    check("drain_scall_stall_ex", {31'd0, o_stall_ex}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_drain",
          {25'd0, o_stall_if, o_stall_id, o_stall_ex, o_stall_mem, o_flush_id, o_flush_ex, o_halted},
          32'd0);
    next(); next();
    rst = 1'b0;
    next();
    settle();
    check("post_rst_halted", {31'd0, o_halted}, 32'd0);
    next();

`ifdef HAZARD_PERF_CNT_EN
    settle();
    dut.stall_cycles_q = 32'hFFFF_FFFF;
    load_use_x5();
    next(); idle();
    settle();
    check("perf_stall_wrap", o_stall_cycles, 32'd0);
    check("perf_flush_cnt", o_flush_events, m_flushes);
    br = 1'b1;
    next(); idle();
    br = 1'b1;
    next(); idle();
    settle();
    check("perf_flush_after_br", o_flush_events, m_flushes);
    next();
`endif

    next();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
